// File: rtl/replica_timing_monitor_pkg.sv
// Shared types and helpers for the replica timing monitor.
package timing_mon_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    CAPTURE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  // One sample occupies LAUNCH, CAPTURE and CHECK
  localparam int CYCLES_PER_SAMPLE = 3;

  // Inverter count from the chain input to tap k
  function automatic int tap_len(input int k, input int base, input int step);
    return base + k * step;
  endfunction

endpackage

// File: rtl/replica_timing_monitor_if.sv
// Control/status bundle between a host and the replica timing monitor.
interface replica_timing_monitor_if #(
  parameter int SEL_W = 3,
  parameter int WIN_W = 12,
  parameter int CNT_W = 12
);

  logic             enable_i;
  logic [SEL_W-1:0] tap_sel_i;
  logic [WIN_W-1:0] window_i;
  logic [CNT_W-1:0] thresh_i;
  logic             alarm_clr_i;
  logic             fault_inject_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] err_count_o;
  logic             alarm_o;

  // Host side: drives the controls, observes status
  modport master (
    output enable_i, tap_sel_i, window_i, thresh_i, alarm_clr_i, fault_inject_i,
    input  busy_o, done_o, err_count_o, alarm_o
  );

  // Monitor side
  modport slave (
    input  enable_i, tap_sel_i, window_i, thresh_i, alarm_clr_i, fault_inject_i,
    output busy_o, done_o, err_count_o, alarm_o
  );

endinterface

// File: rtl/replica_timing_monitor_tap_chain.sv
// Tap-selectable inverter chain used as a critical-path delay replica.
// Every tap sits an even number of inversions from the input, so each tap
// follows the launch value once the chain has settled.
module replica_tap_chain
  import timing_mon_pkg::*;
#(
  parameter int BASE_STAGES = 188,
  parameter int TAP_STEP    = 8,
  parameter int NUM_TAPS    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        launch,
  input  logic                        sel_load,
  input  logic [$clog2(NUM_TAPS)-1:0] sel,
  output logic                        tap
);

  localparam int LONGEST = tap_len(NUM_TAPS - 1, BASE_STAGES, TAP_STEP);

  // Chain nets are preserved so synthesis keeps the full inverter count
  (* keep = "true", dont_touch = "true" *) logic [LONGEST:0] node;
  logic [NUM_TAPS-1:0]         taps;
  logic [$clog2(NUM_TAPS)-1:0] tap_q;

  // Ripple the launch value through LONGEST inverters
  always_comb begin
    node    = '0;
    node[0] = launch;
    for (int i = 0; i < LONGEST; i++) begin
      node[i+1] = ~node[i];
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign taps[k] = node[tap_len(k, BASE_STAGES, TAP_STEP)];
  end

  // Tap select is latched once per window so mid-window changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= '0;
    end else if (sel_load) begin
      tap_q <= sel;
    end
  end

  assign tap = taps[tap_q];

endmodule

// File: rtl/replica_timing_monitor.sv
// Timing-margin sensor: launches transitions into a delay replica, captures
// the replica output one clock later and counts late arrivals per window.
// A sticky alarm is raised when a window's error count reaches a threshold.
module replica_timing_monitor
  import timing_mon_pkg::*;
#(
  parameter int BASE_STAGES = 188,
  parameter int TAP_STEP    = 8,
  parameter int NUM_TAPS    = 8,
  parameter int WIN_W       = 12,
  parameter int CNT_W       = 12
) (
  input logic                     clk_i,
  input logic                     rst_i,
  replica_timing_monitor_if.slave bus
);

  state_t           state_q, state_d;
  logic             launch_q, capture_q;
  logic [WIN_W-1:0] win_rem_q, rem_next;
  logic [CNT_W-1:0] run_cnt_q, cnt_next, err_count_q;
  logic             done_q, alarm_q;
  logic             tap_out;
  logic             sample_err, alarm_set;
  logic             load_win, do_launch, do_capture, do_check, finish;

  // Error counter increments stick at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != '1)) return cnt + 1'b1;
    return cnt;
  endfunction

  // A zero-length window still measures one sample
  function automatic logic [WIN_W-1:0] win_load(input logic [WIN_W-1:0] win);
    if (win == '0) return {{(WIN_W-1){1'b0}}, 1'b1};
    return win;
  endfunction

  replica_tap_chain #(
    .BASE_STAGES (BASE_STAGES),
    .TAP_STEP    (TAP_STEP),
    .NUM_TAPS    (NUM_TAPS)
  ) u_chain (
    .clk      (clk_i),
    .rst      (rst_i),
    .launch   (launch_q),
    .sel_load (load_win),
    .sel      (bus.tap_sel_i),
    .tap      (tap_out)
  );

  assign sample_err = capture_q ^ launch_q;
  assign cnt_next   = sat_inc(run_cnt_q, sample_err);
  assign rem_next   = win_rem_q - 1'b1;
  assign alarm_set  = finish && (bus.thresh_i != '0) && (cnt_next >= bus.thresh_i);

  // Next-state and per-state action strobes
  always_comb begin
    state_d    = state_q;
    load_win   = 1'b0;
    do_launch  = 1'b0;
    do_capture = 1'b0;
    do_check   = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          load_win = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!bus.enable_i) begin
          state_d = IDLE;
        end else begin
          do_launch = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        // Capture always completes; an abort is honoured in CHECK
        do_capture = 1'b1;
        state_d    = CHECK;
      end
      CHECK: begin
        if (!bus.enable_i) begin
          state_d = IDLE;
        end else begin
          do_check = 1'b1;
          if (rem_next == '0) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Launch/capture flops and the per-window sample/error counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      launch_q  <= 1'b0;
      capture_q <= 1'b0;
      win_rem_q <= '0;
      run_cnt_q <= '0;
    end else begin
      if (do_launch)  launch_q  <= ~launch_q;
      if (do_capture) capture_q <= tap_out ^ bus.fault_inject_i;
      if (load_win) begin
        win_rem_q <= win_load(bus.window_i);
        run_cnt_q <= '0;
      end else if (do_check) begin
        win_rem_q <= rem_next;
        run_cnt_q <= cnt_next;
      end
    end
  end

  // Window result, completion pulse and sticky alarm (set beats clear)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q <= '0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish)               err_count_q <= cnt_next;
      if (alarm_set)            alarm_q     <= 1'b1;
      else if (bus.alarm_clr_i) alarm_q     <= 1'b0;
    end
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;
  assign bus.err_count_o = err_count_q;
  assign bus.alarm_o     = alarm_q;

endmodule

// File: tb/tb_replica_timing_monitor.sv
// Directed bench for replica_timing_monitor: a table of whole-window
// vectors plus hand-written reset, abort and tap-latch sequences.
module tb_replica_timing_monitor;
  import timing_mon_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  replica_timing_monitor_if #(.SEL_W(3), .WIN_W(12), .CNT_W(CW)) bus ();

  replica_timing_monitor #(
    .BASE_STAGES (188),
    .TAP_STEP    (8),
    .NUM_TAPS    (8),
    .WIN_W       (12),
    .CNT_W       (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int win;        // window_i
    int th;         // thresh_i
    int nf;         // number of leading samples with fault injected
    bit pre_clr;    // pulse alarm_clr_i before the window
    bit hold_clr;   // hold alarm_clr_i across the window
    int exp_err;
    int exp_alarm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input vec_t v, input string tag);
    int eff;
    int last;
    int done_at;
    eff  = (v.win == 0) ? 1 : v.win;
    last = CYCLES_PER_SAMPLE * eff + 1;
    if (v.pre_clr) begin
      @(negedge clk);
      bus.alarm_clr_i = 1'b1;
      @(negedge clk);
      bus.alarm_clr_i = 1'b0;
    end
    @(negedge clk);
    bus.window_i       = 12'(v.win);
    bus.thresh_i       = CW'(v.th);
    bus.alarm_clr_i    = v.hold_clr;
    bus.fault_inject_i = 1'b0;
    bus.enable_i       = 1'b1;
    done_at = 0;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 && done_at == 0) done_at = t;
      // State after edge t is CAPTURE of sample (t-2)/3 when (t-2)%3==0
      bus.fault_inject_i = (t >= 2) && ((t - 2) % 3 == 0) && ((t - 2) / 3 < v.nf);
    end
    bus.enable_i       = 1'b0;
    bus.fault_inject_i = 1'b0;
    chk({tag, " latency"}, done_at, last);
    chk({tag, " err_count"}, bus.err_count_o, v.exp_err);
    chk({tag, " alarm"}, bus.alarm_o, v.exp_alarm);
    @(negedge clk);
    chk({tag, " done one cycle"}, bus.done_o, 0);
    chk({tag, " idle after"}, bus.busy_o, 0);
    if (v.hold_clr) chk({tag, " clear after set"}, bus.alarm_o, 0);
    bus.alarm_clr_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int idle_at;
    bit done_seen;
    vec_t rv;

    vecs[0] = '{10, 0,  0, 1'b1, 1'b0,  0, 0};  // clean window
    vecs[1] = '{10, 4,  4, 1'b1, 1'b0,  4, 1};  // threshold reached
    vecs[2] = '{10, 4,  3, 1'b0, 1'b0,  3, 1};  // alarm sticky below threshold
    vecs[3] = '{10, 4,  3, 1'b1, 1'b0,  3, 0};  // cleared, below threshold
    vecs[4] = '{20, 0, 20, 1'b1, 1'b0, 15, 0};  // saturation, alarm disabled
    vecs[5] = '{ 0, 1,  1, 1'b1, 1'b0,  1, 1};  // window 0 acts as 1
    vecs[6] = '{ 1, 1,  0, 1'b1, 1'b0,  0, 0};  // single clean sample
    vecs[7] = '{ 3, 1,  1, 1'b1, 1'b1,  1, 1};  // set wins over held clear
    vecs[8] = '{20, 15, 17, 1'b1, 1'b0, 15, 1}; // saturated count meets threshold
    vecs[9] = '{ 5, 15, 5, 1'b1, 1'b0,  5, 0};  // below threshold

    bus.enable_i       = 1'b1;
    bus.tap_sel_i      = 3'd0;
    bus.window_i       = 12'd4;
    bus.thresh_i       = '0;
    bus.alarm_clr_i    = 1'b0;
    bus.fault_inject_i = 1'b0;

    // Reset held with enable high
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy_o, 0);
    chk("reset done", bus.done_o, 0);
    chk("reset err_count", bus.err_count_o, 0);
    chk("reset alarm", bus.alarm_o, 0);

    // Release: first window starts immediately, done after 3*4+1 edges
    rst = 1'b0;
    done_at = 0;
    for (int t = 1; t <= 13; t++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 && done_at == 0) done_at = t;
    end
    bus.enable_i = 1'b0;
    chk("post-reset latency", done_at, 13);
    chk("post-reset err_count", bus.err_count_o, 0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      rv = vecs[i];
      run_window(rv, $sformatf("vec%0d", i));
    end

    // Abort during the 5th sample with faults on: result must be discarded
    @(negedge clk);
    bus.window_i       = 12'd10;
    bus.thresh_i       = CW'(1);
    bus.fault_inject_i = 1'b1;
    bus.enable_i       = 1'b1;
    for (int t = 1; t <= 14; t++) @(negedge clk);
    bus.enable_i = 1'b0;
    idle_at   = 0;
    done_seen = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b0 && idle_at == 0) idle_at = k;
      if (bus.done_o === 1'b1) done_seen = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) done_seen = 1'b1;
    end
    bus.fault_inject_i = 1'b0;
    chk("abort busy drops", (idle_at != 0), 1);
    chk("abort no done", done_seen, 0);
    chk("abort err_count held", bus.err_count_o, 5);
    chk("abort alarm held", bus.alarm_o, 0);

    // Tap select latched per window
    @(negedge clk);
    bus.tap_sel_i = 3'd0;
    bus.window_i  = 12'd3;
    bus.thresh_i  = '0;
    bus.enable_i  = 1'b1;
    done_at = 0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 2) bus.tap_sel_i = 3'd7;
      if (t == 5) chk("tap held mid-window", dut.u_chain.tap_q, 0);
      if (bus.done_o === 1'b1 && done_at == 0) done_at = t;
    end
    chk("tap window latency", done_at, 10);
    @(negedge clk);
    chk("tap latched next window", dut.u_chain.tap_q, 7);
    bus.enable_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("tap abort idle", bus.busy_o, 0);

    // Build nonzero status, then reset during CAPTURE
    rv = '{2, 1, 2, 1'b1, 1'b0, 2, 1};
    run_window(rv, "pre-reset");
    @(negedge clk);
    bus.window_i = 12'd10;
    bus.enable_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset busy", bus.busy_o, 0);
    chk("mid reset done", bus.done_o, 0);
    chk("mid reset err_count", bus.err_count_o, 0);
    chk("mid reset alarm", bus.alarm_o, 0);
    bus.enable_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/replica_timing_monitor.md
Name: replica_timing_monitor

Overview:
- Parametrised, tap-selectable critical-path delay replica with an on-chip measurement controller.
- Repeatedly launches a transition into an inverter chain, captures the chain output one clock later, and counts late arrivals over a programmable window.
- Raises a sticky alarm when the error count reaches a threshold.
- Sits beside the divider/execute stage as a timing-margin sensor for the error-resilient pipeline.

Parameters:
- BASE_STAGES, 188, inverter count at tap 0; must be even.
- TAP_STEP, 8, extra inverters per tap increment; must be even.
- NUM_TAPS, 8, number of selectable taps. Longest chain is BASE_STAGES + (NUM_TAPS-1)*TAP_STEP.
- WIN_W, 12, width of the window sample count.
- CNT_W, 12, width of the error counters.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  run measurements while high
- tap_sel_i  in  $clog2(NUM_TAPS)  replica length select
- window_i  in  WIN_W  launches per window; 0 is treated as 1
- thresh_i  in  CNT_W  alarm threshold; 0 disables the alarm
- alarm_clr_i  in  1  clears alarm_o
- fault_inject_i  in  1  verification hook; inverts the captured sample
- busy_o  out  1  window in progress
- done_o  out  1  one-cycle pulse when a window completes
- err_count_o  out  CNT_W  error count of the last completed window
- alarm_o  out  1  sticky threshold alarm

Behaviour:
- Reset: clk_i and rst_i are the only clock and reset. Reset is synchronous and active-high.
  - On rst_i, every flop clears: state=IDLE, launch_q=0, capture_q=0, all counters 0.
  - All outputs are 0 during and after reset.
  - Reset asserted mid-window aborts the window. No done_o pulse is produced.
- Chain: launch_q drives tap chain input. Tap k is the output after BASE_STAGES + k*TAP_STEP inverters. Every tap is non-inverting.
- FSM states are IDLE, LAUNCH, CAPTURE, CHECK.
- IDLE:
  - busy_o=0.
  - When enable_i=1: latch tap_sel_i into tap_q and max(window_i,1) into win_rem; clear run_cnt; go to LAUNCH.
  - tap_sel_i changes made during a window are ignored until the next window.
- LAUNCH: launch_q toggles at the exit edge. Go to CAPTURE.
- CAPTURE: capture_q <= tap[tap_q] ^ fault_inject_i at the exit edge. Go to CHECK.
- CHECK:
  - If capture_q != launch_q, run_cnt increments, saturating at all-ones.
  - win_rem decrements.
  - If the new win_rem=0: err_count_o <= final run_cnt (including this sample); done_o=1 for the next cycle; go to IDLE. IDLE restarts at once if enable_i is still high.
  - Otherwise, go to LAUNCH.
- Timing: each sample takes 3 cycles. Window latency is 3*N cycles from leaving IDLE to the done_o pulse, plus 1 cycle to restart.
- enable_i deasserted mid-window: finish the current state's edge, then go to IDLE from the next LAUNCH or CHECK. Discard run_cnt. err_count_o and alarm_o hold their values. No done_o pulse.
- Alarm:
  - On window completion, if thresh_i!=0 and the final count >= thresh_i, set alarm_o.
  - alarm_clr_i clears alarm_o. If clear and set occur in the same cycle, set wins.
- Zero-delay simulation sees no natural errors. Errors are produced only via fault_inject_i.
- Synthesis: chain cells carry keep/dont_touch so they are not collapsed.

Decomposition:
- Shared package timing_mon_pkg: FSM state enum, CYCLES_PER_SAMPLE=3, helper function tap_len(k).
- Sub-module replica_tap_chain: generate-loop inverter chain with NUM_TAPS tap outputs and a registered-select mux. The controller stays in the top module.

Test Plan:
- Reset: hold rst_i with enable_i=1 -> all outputs 0. After release, done_o fires exactly 3*window_i+1 cycles later.
- Clean window: window_i=10, fault_inject_i=0 -> done_o pulse, err_count_o=0, alarm_o=0.
- Injected errors: window_i=10, fault_inject_i high for 4 CAPTURE states, thresh_i=4 -> err_count_o=4, alarm_o=1. Then alarm_clr_i -> alarm_o=0.
- Saturation: CNT_W=4, window_i=20, fault_inject_i=1 throughout -> err_count_o=15. window_i=0 -> done_o after a single 3-cycle sample.
- Abort: drop enable_i during the 5th sample -> no done_o, err_count_o keeps its prior value, busy_o=0 within 3 cycles.
- Mid-window changes: change tap_sel_i from 0 to 7 mid-window -> tap_q stays 0 until the next window. Assert rst_i during CAPTURE -> next cycle is IDLE with all outputs 0.
